// File: rtl/adc_sample_buffer.sv
// ADC capture buffer: after an arm pulse, stores DEPTH consecutive samples and tracks
// their min/max, then streams the record out one word per read request.
module adc_sample_buffer #(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    input  logic              arm,
    input  logic              rd_req,
    output logic              busy,
    output logic              capture_done,
    output logic [ADDR_W:0]   count,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_last,
    output logic [DATA_W-1:0] min_val,
    output logic [DATA_W-1:0] max_val
);
    typedef enum logic [1:0] {IDLE, CAPTURE, FULL} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              start, wr_en, rd_en;

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next   = state;
        start        = 1'b0;
        wr_en        = 1'b0;
        rd_en        = 1'b0;
        busy         = 1'b0;
        capture_done = 1'b0;
        case (state)
            IDLE: begin
                if (arm) begin
                    start      = 1'b1;
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                busy = 1'b1;
                if (sample_valid) begin
                    wr_en = 1'b1;
                    if (wr_ptr == '1) state_next = FULL;
                end
            end
            FULL: begin
                capture_done = 1'b1;
                // arm has priority over a simultaneous read request
                if (arm) begin
                    start      = 1'b1;
                    state_next = CAPTURE;
                end else if (rd_req) begin
                    rd_en = 1'b1;
                    if (rd_ptr == '1) state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(negedge clk) begin
        if (wr_en) mem[wr_ptr] <= sample_in;
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst)       rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_ptr];
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            min_val  <= '1;
            max_val  <= '0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            rd_last  <= rd_en && (rd_ptr == '1);
            if (start) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count   <= '0;
                min_val <= '1;
                max_val <= '0;
            end else begin
                // count stops at DEPTH because the last write leaves CAPTURE
                if (wr_en) begin
                    wr_ptr <= wr_ptr + ADDR_W'(1);
                    count  <= count + (ADDR_W+1)'(1);
                    if (sample_in < min_val) min_val <= sample_in;
                    if (sample_in > max_val) max_val <= sample_in;
                end
                if (rd_en) rd_ptr <= rd_ptr + ADDR_W'(1);
            end
        end
    end
endmodule

// File: doc/adc_sample_buffer.md
Name: adc_sample_buffer

Overview:
Capture buffer directly downstream of the ADC reader. It takes each completed 12-bit conversion word plus a one-cycle valid strobe and stores DEPTH consecutive samples into an on-chip RAM after an arm pulse. It tracks min/max over the capture window. Once the buffer is full, contents are streamed out one word per request. It replaces the single-sample storage register so the failure-twinning logic can compare a full record of waveform data.

Parameters:
DATA_W, 12, width of one ADC sample
DEPTH, 64, samples per capture window (power of two, >= 2)
ADDR_W, 6, log2(DEPTH); width of write/read pointers

Ports:
clk  input  1  50MHz FPGA clock; all state updates on negedge clk
rst  input  1  asynchronous active-low reset
sample_in  input  DATA_W  conversion word from ADC reader, stable while sample_valid=1
sample_valid  input  1  one-cycle strobe per completed 12-bit conversion
arm  input  1  one-cycle pulse: start a new capture window
rd_req  input  1  request next stored word (honoured only in FULL)
busy  output  1  high while in CAPTURE
capture_done  output  1  high while in FULL (buffer holds a complete window)
count  output  ADDR_W+1  samples written in the current window, 0..DEPTH
rd_data  output  DATA_W  read word
rd_valid  output  1  one-cycle strobe qualifying rd_data
rd_last  output  1  high with rd_valid on the DEPTH-th word of a readout
min_val  output  DATA_W  minimum sample of current window
max_val  output  DATA_W  maximum sample of current window

Behaviour:
- Reset (rst=0, async): state=IDLE; busy=0, capture_done=0, count=0, rd_data=0, rd_valid=0, rd_last=0, min_val=12'hFFF, max_val=0, wr_ptr=rd_ptr=0. RAM contents are undefined. Reset mid-capture or mid-readout abandons the operation with no further writes or reads.
- States: IDLE, CAPTURE, FULL.
- IDLE:
  - arm=1 -> CAPTURE on the next edge; clear count, wr_ptr, rd_ptr; load min_val=12'hFFF, max_val=0.
  - sample_valid and rd_req are ignored.
- CAPTURE (busy=1):
  - On each edge with sample_valid=1: mem[wr_ptr]<=sample_in; wr_ptr+1; count+1.
  - min_val<=min(min_val,sample_in) and max_val<=max(max_val,sample_in), unsigned compare, updated in the same edge.
  - The write that makes count=DEPTH moves to FULL on that same edge. wr_ptr wraps to 0 and is not used again.
  - arm during CAPTURE is ignored. rd_req is ignored.
- FULL (capture_done=1, busy=0):
  - sample_valid is ignored; the buffer, count, min and max are frozen.
  - rd_req=1 at edge N: at edge N+1, rd_data=mem[rd_ptr] and rd_valid=1 for exactly one cycle; rd_ptr+1. This is a fixed 1-cycle latency.
  - Back-to-back rd_req on consecutive edges gives back-to-back rd_valid.
  - rd_ptr=DEPTH-1 read: rd_last=1 with that rd_valid. The state returns to IDLE on the edge that issues it, so capture_done falls together with the rd_last assertion. count, min and max hold their values until the next arm.
  - arm in FULL restarts: -> CAPTURE with the same clears as from IDLE; arm beats rd_req if both are high. A read already issued still completes its rd_valid on the following edge.
- rd_valid and rd_last are otherwise 0. rd_data holds its last value between reads.
- count saturates at DEPTH and never wraps. wr_ptr and rd_ptr are ADDR_W bits and wrap naturally.
- RAM: single write port, single registered read port, inferable as block RAM.

Test Plan:
- Reset then idle: rst low for 3 cycles with sample_valid toggling -> count=0, busy=0, min_val=12'hFFF, max_val=0; arm never given -> no change after 100 strobes.
- Full capture: arm, then 64 strobes of values 0x100+i -> busy=1 until the 64th strobe, then capture_done=1, count=64, min_val=0x100, max_val=0x13F; a 65th strobe leaves count=64.
- Readout: in FULL, hold rd_req high for 64 cycles -> 64 consecutive rd_valid with rd_data 0x100..0x13F in order, 1-cycle latency, rd_last only on 0x13F; state IDLE afterwards; a further rd_req gives no rd_valid.
- Re-arm mid-readout: read 10 words, then arm and rd_req together -> CAPTURE entered, min/max cleared, count=0, at most one trailing rd_valid (word 10).
- Async reset mid-capture: rst low after 20 strobes between clock edges -> outputs return to reset values immediately; after release, strobes without arm leave count=0.
- Extremes: capture with samples 0xFFF, 0x000 interleaved, DEPTH=4 override -> min_val=0x000, max_val=0xFFF, count=4, capture_done after the 4th strobe.
